// File: rtl/memory_stage.sv
// MEM stage: EX/MEM register, data-memory handshake, load/store lane logic,
// and the MEM/WB register feeding writeback.
module memory_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWriteE,
  input  logic [1:0]        ResultSrcE,
  input  logic              MemWriteE,
  input  logic [2:0]        funct3E,
  input  logic [31:0]       ALUResultE,
  input  logic [DATA_W-1:0] WriteDataE,
  input  logic [4:0]        RdE,
  input  logic [31:0]       PCPlus4E,
  input  logic              FlushM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              StallM,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [31:0]       ALUResultW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [4:0]        RdW,
  output logic [31:0]       PCPlus4W,
  output logic              MisalignW
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state;
  logic              rw_m;
  logic [1:0]        rs_m;
  logic              mw_m;
  logic [2:0]        f3_m;
  logic [31:0]       alu_m;
  logic [DATA_W-1:0] wd_m;
  logic [4:0]        rd_m;
  logic [31:0]       pc4_m;

  logic              is_store;
  logic              is_load;
  logic              misalign;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [DATA_W-1:0] load_data;

  assign is_store = mw_m;
  assign is_load  = (rs_m == 2'b01) & ~mw_m;
  assign misalign = (is_store | is_load) &
                    (((f3_m[1:0] == 2'b01) & alu_m[0]) |
                     ((f3_m[1:0] == 2'b10) & (|alu_m[1:0])));

  always_comb begin
    dmem_req = 1'b0;
    StallM   = 1'b0;
    unique case (state)
      S_IDLE: begin
        dmem_req = (is_store | is_load) & ~misalign;
        StallM   = dmem_req & ~(dmem_gnt & is_store);
      end
      S_WAIT: StallM = ~dmem_rvalid;
      default: ;
    endcase
  end

  always_comb begin
    be    = 4'b1111;
    wdata = wd_m;
    unique case (1'b1)
      f3_m[1:0] == 2'b00: begin
        be    = 4'b0001 << alu_m[1:0];
        wdata = {4{wd_m[7:0]}};
      end
      f3_m[1:0] == 2'b01: begin
        be    = 4'b0011 << alu_m[1:0];
        wdata = {2{wd_m[15:0]}};
      end
      default: ;
    endcase
  end

  assign dmem_we    = dmem_req & is_store;
  assign dmem_be    = dmem_we ? be : 4'b0000;
  assign dmem_wdata = wdata;
  assign dmem_addr  = {alu_m[ADDR_W-1:2], 2'b00};

  assign lane_b = dmem_rdata[{alu_m[1:0], 3'b000} +: 8];
  assign lane_h = dmem_rdata[{alu_m[1], 4'b0000} +: 16];

  always_comb begin
    load_data = dmem_rdata;
    unique case (1'b1)
      f3_m == 3'b000: load_data = {{24{lane_b[7]}}, lane_b};
      f3_m == 3'b100: load_data = {24'h0, lane_b};
      f3_m == 3'b001: load_data = {{16{lane_h[15]}}, lane_h};
      f3_m == 3'b101: load_data = {16'h0, lane_h};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rw_m       <= 1'b0;
      rs_m       <= 2'b00;
      mw_m       <= 1'b0;
      f3_m       <= 3'b000;
      alu_m      <= '0;
      wd_m       <= '0;
      rd_m       <= '0;
      pc4_m      <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      RdW        <= '0;
      PCPlus4W   <= '0;
      MisalignW  <= 1'b0;
    end else begin
      if (!StallM) begin
        rw_m  <= RegWriteE & ~FlushM;
        rs_m  <= FlushM ? 2'b00 : ResultSrcE;
        mw_m  <= MemWriteE & ~FlushM;
        f3_m  <= funct3E;
        alu_m <= ALUResultE;
        wd_m  <= WriteDataE;
        rd_m  <= RdE;
        pc4_m <= PCPlus4E;
      end
      unique case (state)
        S_IDLE: if (dmem_req && dmem_gnt && is_load) state <= S_WAIT;
        S_WAIT: if (dmem_rvalid) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // stalled cycles hand writeback a bubble
      if (StallM) begin
        RegWriteW  <= 1'b0;
        ResultSrcW <= 2'b00;
        ALUResultW <= '0;
        ReadDataW  <= '0;
        RdW        <= '0;
        PCPlus4W   <= '0;
        MisalignW  <= 1'b0;
      end else begin
        RegWriteW  <= rw_m & ~misalign;
        ResultSrcW <= rs_m;
        ALUResultW <= alu_m;
        ReadDataW  <= (is_load & ~misalign) ? load_data : '0;
        RdW        <= rd_m;
        PCPlus4W   <= pc4_m;
        MisalignW  <= misalign;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: per-cycle compare against a
// spec-level model of handshake timing, lane logic and writeback.
module tb_memory_stage;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] pc4;
  } op_t;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic        mis;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteE;
  logic [1:0]  ResultSrcE;
  logic        MemWriteE;
  logic [2:0]  funct3E;
  logic [31:0] ALUResultE;
  logic [31:0] WriteDataE;
  logic [4:0]  RdE;
  logic [31:0] PCPlus4E;
  logic        FlushM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        StallM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [4:0]  RdW;
  logic [31:0] PCPlus4W;
  logic        MisalignW;

  memory_stage dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .MemWriteE(MemWriteE), .funct3E(funct3E),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
    .RdE(RdE), .PCPlus4E(PCPlus4E), .FlushM(FlushM),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .StallM(StallM), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W),
    .MisalignW(MisalignW)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        chk_en = 1'b0;
  logic        e_req, e_we, e_stall, e_full;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_be;
  wb_t         e_wb;

  op_t NOP;
  op_t JUNK;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic misal(input logic [2:0] f3, input logic [31:0] a);
    int sz = int'(f3 % 4);
    return (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
  endfunction

  function automatic logic [3:0] be_model(input logic [2:0] f3,
                                          input logic [31:0] a);
    int sz = int'(f3 % 4);
    int sh = int'(a % 4);
    if (sz == 0) return 4'(1 << sh);
    if (sz == 1) return 4'(3 << sh);
    return 4'hF;
  endfunction

  function automatic logic [31:0] wd_model(input logic [2:0] f3,
                                           input logic [31:0] wd);
    int sz = int'(f3 % 4);
    if (sz == 0) return (wd & 32'hFF) * 32'h01010101;
    if (sz == 1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] ld_model(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> ((a % 4) * 8)) & 32'hFF;
    h = (rd >> (((a % 4) / 2) * 16)) & 32'hFFFF;
    case (f3)
      3'b000: return (b >= 128) ? b - 256 : b;
      3'b100: return b;
      3'b001: return (h >= 32768) ? h - 65536 : h;
      3'b101: return h;
      default: return rd;
    endcase
  endfunction

  function automatic wb_t model(input op_t o, input logic [31:0] rdata);
    wb_t w;
    logic st, ld, mis;
    st = o.mw;
    ld = (o.rs == 2'b01) && !st;
    mis = (ld || st) && misal(o.f3, o.alu);
    w.rw = o.rw && !mis;
    w.rs = o.rs;
    w.alu = o.alu;
    w.rd = o.rd;
    w.pc4 = o.pc4;
    w.mis = mis;
    w.rdata = (ld && !mis) ? ld_model(o.f3, o.alu, rdata) : 32'h0;
    return w;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("StallM", 32'(StallM), 32'(e_stall));
      chk("dmem_req", 32'(dmem_req), 32'(e_req));
      if (e_req) begin
        chk("dmem_addr", dmem_addr, e_addr);
        chk("dmem_we", 32'(dmem_we), 32'(e_we));
        if (e_we) begin
          chk("dmem_be", 32'(dmem_be), 32'(e_be));
          chk("dmem_wdata", dmem_wdata, e_wdata);
        end
      end else begin
        chk("dmem_be_idle", 32'(dmem_be), 32'h0);
      end
      chk("RegWriteW", 32'(RegWriteW), 32'(e_wb.rw));
      chk("MisalignW", 32'(MisalignW), 32'(e_wb.mis));
      if (e_full) begin
        chk("ResultSrcW", 32'(ResultSrcW), 32'(e_wb.rs));
        chk("ALUResultW", ALUResultW, e_wb.alu);
        chk("ReadDataW", ReadDataW, e_wb.rdata);
        chk("RdW", 32'(RdW), 32'(e_wb.rd));
        chk("PCPlus4W", PCPlus4W, e_wb.pc4);
      end
    end
  end

  task automatic drive(input op_t o, input logic fl);
    RegWriteE  = o.rw;
    ResultSrcE = o.rs;
    MemWriteE  = o.mw;
    funct3E    = o.f3;
    ALUResultE = o.alu;
    WriteDataE = o.wd;
    RdE        = o.rd;
    PCPlus4E   = o.pc4;
    FlushM     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one op from an empty EX/MEM; returns in the cycle its MEM/WB
  // result is visible, with EX/MEM empty again.
  task automatic run_op(input op_t o, input logic fl, input int gd,
                        input int rv, input logic [31:0] rdata,
                        input logic junk);
    op_t  eff;
    logic st, ld, mis, mem;
    eff = o;
    if (fl) begin
      eff.rw = 1'b0;
      eff.mw = 1'b0;
      eff.rs = 2'b00;
    end
    st  = eff.mw;
    ld  = (eff.rs == 2'b01) && !st;
    mis = (ld || st) && misal(eff.f3, eff.alu);
    mem = (ld || st) && !mis;
    drive(o, fl);
    e_req = 1'b0;
    e_stall = 1'b0;
    step();
    drive(NOP, 1'b0);
    e_wb = '0;
    e_full = 1'b1;
    if (mem) begin
      e_addr  = eff.alu & ~32'h3;
      e_we    = st;
      e_be    = be_model(eff.f3, eff.alu);
      e_wdata = wd_model(eff.f3, eff.wd);
      for (int k = 0; k <= gd; k++) begin
        dmem_gnt = (k == gd);
        e_req = 1'b1;
        e_stall = ld || (k < gd);
        if (e_stall && junk) drive(JUNK, 1'b1);
        else drive(NOP, 1'b0);
        step();
        e_full = 1'b0;
      end
      dmem_gnt = 1'b0;
      e_req = 1'b0;
      if (ld) begin
        for (int j = 1; j <= rv; j++) begin
          dmem_rvalid = (j == rv);
          dmem_rdata = (j == rv) ? rdata : 32'hDEADBEEF;
          e_stall = (j < rv);
          if (e_stall && junk) drive(JUNK, 1'b1);
          else drive(NOP, 1'b0);
          step();
          e_full = 1'b0;
        end
      end
      dmem_rvalid = 1'b0;
    end else begin
      e_req = 1'b0;
      e_stall = 1'b0;
      step();
    end
    e_wb = model(eff, rdata);
    e_full = 1'b1;
    e_req = 1'b0;
    e_stall = 1'b0;
  endtask

  initial begin
    op_t o;
    NOP = '0;
    JUNK = '{rw: 1'b0, rs: 2'b00, mw: 1'b1, f3: 3'b010,
             alu: 32'h500, wd: 32'h0BADF00D, rd: 5'd0, pc4: 32'h0};
    rst_n = 1'b0;
    drive(NOP, 1'b0);
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata = 32'h0;
    e_req = 1'b0; e_we = 1'b0; e_stall = 1'b0; e_full = 1'b1;
    e_addr = '0; e_wdata = '0; e_be = '0; e_wb = '0;
    step();
    step();
    chk_en = 1'b1;
    chk("dmem_we_rst", 32'(dmem_we), 32'h0);
    rst_n = 1'b1;
    step();

    // ALU op
    o = '{rw: 1'b1, rs: 2'b00, mw: 1'b0, f3: 3'b000,
          alu: 32'h1234, wd: 32'h0, rd: 5'd5, pc4: 32'h1008};
    run_op(o, 1'b0, 0, 0, 32'h0, 1'b0);
    chk("alu_lit_rw", 32'(RegWriteW), 32'h1);
    chk("alu_lit_res", ALUResultW, 32'h1234);

    // LB / LBU at 0x103
    o = '{rw: 1'b1, rs: 2'b01, mw: 1'b0, f3: 3'b000,
          alu: 32'h103, wd: 32'h0, rd: 5'd6, pc4: 32'h100C};
    run_op(o, 1'b0, 0, 1, 32'h80AABBCC, 1'b0);
    chk("lb_lit", ReadDataW, 32'hFFFFFF80);
    o.f3 = 3'b100;
    run_op(o, 1'b0, 0, 1, 32'h80AABBCC, 1'b0);
    chk("lbu_lit", ReadDataW, 32'h00000080);

    // SH at 0x22, gnt after 3 cycles
    chk("model_sh_be", 32'(be_model(3'b001, 32'h22)), 32'hC);
    chk("model_sh_wd", wd_model(3'b001, 32'h0000BEEF), 32'hBEEFBEEF);
    o = '{rw: 1'b0, rs: 2'b00, mw: 1'b1, f3: 3'b001,
          alu: 32'h22, wd: 32'h0000BEEF, rd: 5'd0, pc4: 32'h1010};
    run_op(o, 1'b0, 3, 0, 32'h0, 1'b0);

    // Misaligned LW
    o = '{rw: 1'b1, rs: 2'b01, mw: 1'b0, f3: 3'b010,
          alu: 32'h41, wd: 32'h0, rd: 5'd9, pc4: 32'h1014};
    run_op(o, 1'b0, 0, 1, 32'h0, 1'b0);
    chk("mis_lit", 32'(MisalignW), 32'h1);
    chk("mis_lit_rw", 32'(RegWriteW), 32'h0);

    // Flushed store
    o = '{rw: 1'b0, rs: 2'b00, mw: 1'b1, f3: 3'b010,
          alu: 32'h80, wd: 32'h11223344, rd: 5'd0, pc4: 32'h1018};
    run_op(o, 1'b1, 0, 0, 32'h0, 1'b0);

    // LW with flush and junk store offered during its stall
    o = '{rw: 1'b1, rs: 2'b01, mw: 1'b0, f3: 3'b010,
          alu: 32'h300, wd: 32'h0, rd: 5'd11, pc4: 32'h101C};
    run_op(o, 1'b0, 1, 3, 32'h12345678, 1'b1);
    chk("lw_lit", ReadDataW, 32'h12345678);

    // Halfword loads, SB, SW, PC+4 op
    o = '{rw: 1'b1, rs: 2'b01, mw: 1'b0, f3: 3'b001,
          alu: 32'h106, wd: 32'h0, rd: 5'd12, pc4: 32'h1020};
    run_op(o, 1'b0, 2, 2, 32'h80010000, 1'b0);
    chk("lh_lit", ReadDataW, 32'hFFFF8001);
    o.f3 = 3'b101;
    o.alu = 32'h102;
    run_op(o, 1'b0, 0, 1, 32'h80010000, 1'b0);
    chk("lhu_lit", ReadDataW, 32'h00008001);
    o = '{rw: 1'b0, rs: 2'b00, mw: 1'b1, f3: 3'b000,
          alu: 32'h13, wd: 32'h1234565A, rd: 5'd0, pc4: 32'h1024};
    run_op(o, 1'b0, 0, 0, 32'h0, 1'b0);
    o = '{rw: 1'b0, rs: 2'b00, mw: 1'b1, f3: 3'b010,
          alu: 32'h40, wd: 32'hCAFEF00D, rd: 5'd0, pc4: 32'h1028};
    run_op(o, 1'b0, 1, 0, 32'h0, 1'b0);
    o = '{rw: 1'b1, rs: 2'b10, mw: 1'b0, f3: 3'b000,
          alu: 32'h77, wd: 32'h0, rd: 5'd1, pc4: 32'h2000};
    run_op(o, 1'b0, 0, 0, 32'h0, 1'b0);

    // Reset while waiting for rvalid
    o = '{rw: 1'b1, rs: 2'b01, mw: 1'b0, f3: 3'b010,
          alu: 32'h200, wd: 32'h0, rd: 5'd7, pc4: 32'h1030};
    drive(o, 1'b0);
    e_req = 1'b0;
    e_stall = 1'b0;
    step();
    drive(NOP, 1'b0);
    dmem_gnt = 1'b1;
    e_req = 1'b1; e_we = 1'b0; e_addr = 32'h200; e_stall = 1'b1;
    e_wb = '0; e_full = 1'b1;
    step();
    dmem_gnt = 1'b0;
    e_req = 1'b0; e_stall = 1'b1; e_full = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h11112222;
    e_req = 1'b0; e_stall = 1'b0; e_wb = '0; e_full = 1'b1;
    step();
    dmem_rvalid = 1'b0;
    step();
    chk("rst_lit_rw", 32'(RegWriteW), 32'h0);
    chk("rst_lit_rd", ReadDataW, 32'h0);

    // Recovery after reset
    o = '{rw: 1'b1, rs: 2'b00, mw: 1'b0, f3: 3'b000,
          alu: 32'hABCD, wd: 32'h0, rd: 5'd3, pc4: 32'h3004};
    run_op(o, 1'b0, 0, 0, 32'h0, 1'b0);
    step();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
